// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Captures decoded operands/control from ID, resolves EX/MEM and MEM/WB
// data hazards for the ALU inputs, and inserts a bubble on load-use hazards.
//
// Ports:
//   clk, reset                         rising-edge clock, sync active-high reset
//   id_*                               decoded operands, indices and control from ID
//   stall, flush                       hold / bubble requests from the pipeline control
//   ex_mem_*, mem_wb_*                 forwarding sources from later stages
//   alu_a, alu_b, alu_op               ALU operands and operation
//   store_data                         forwarded rs2 for stores
//   ex_pc, ex_imm, ex_rd, ex_*         registered pass-through fields and control
//   hazard_stall                       load-use hazard, freezes PC and IF/ID
module id_ex_operand_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             stall,
    input  logic             flush,
    input  logic [RADDR-1:0] ex_mem_rd,
    input  logic             ex_mem_reg_write,
    input  logic [XLEN-1:0]  ex_mem_result,
    input  logic [RADDR-1:0] mem_wb_rd,
    input  logic             mem_wb_reg_write,
    input  logic [XLEN-1:0]  mem_wb_result,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  store_data,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             hazard_stall
);

    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [3:0]       alu_op;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             branch;
    } stage_t;

    stage_t stage_q, stage_d;
    logic   load_use_c;
    logic [XLEN-1:0] fwd_a, fwd_b;

    // Load in EX whose destination is read by the instruction now in ID.
    always_comb begin
        load_use_c = stage_q.mem_read && (stage_q.rd != '0) &&
                     ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2));
    end

    // Next-state: flush and load-use both load an all-zero bubble; stall holds.
    always_comb begin
        stage_d = stage_q;
        if (flush || load_use_c) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d.rs1_data   = id_rs1_data;
            stage_d.rs2_data   = id_rs2_data;
            stage_d.imm        = id_imm;
            stage_d.pc         = id_pc;
            stage_d.rs1        = id_rs1;
            stage_d.rs2        = id_rs2;
            stage_d.rd         = id_rd;
            stage_d.alu_op     = id_alu_op;
            stage_d.alu_src    = id_alu_src;
            stage_d.reg_write  = id_reg_write;
            stage_d.mem_read   = id_mem_read;
            stage_d.mem_write  = id_mem_write;
            stage_d.mem_to_reg = id_mem_to_reg;
            stage_d.branch     = id_branch;
        end
    end

    // Stage register; reset wins over everything, including stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Forwarding select: youngest producer (EX/MEM) first, x0 never forwarded.
    function automatic logic [XLEN-1:0] forward(
        input logic [RADDR-1:0] idx,
        input logic [XLEN-1:0]  reg_data,
        input logic             em_we,
        input logic [RADDR-1:0] em_rd,
        input logic [XLEN-1:0]  em_res,
        input logic             mw_we,
        input logic [RADDR-1:0] mw_rd,
        input logic [XLEN-1:0]  mw_res
    );
        logic [XLEN-1:0] val;
        val = reg_data;
        if (em_we && (em_rd != '0) && (em_rd == idx)) begin
            val = em_res;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
            val = mw_res;
        end
        return val;
    endfunction

    always_comb begin
        fwd_a = forward(stage_q.rs1, stage_q.rs1_data,
                        ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                        mem_wb_reg_write, mem_wb_rd, mem_wb_result);
        fwd_b = forward(stage_q.rs2, stage_q.rs2_data,
                        ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                        mem_wb_reg_write, mem_wb_rd, mem_wb_result);
    end

    // Store data is always the forwarded rs2, independent of the b-operand select.
    assign alu_a         = fwd_a;
    assign alu_b         = stage_q.alu_src ? stage_q.imm : fwd_b;
    assign store_data    = fwd_b;
    assign alu_op        = stage_q.alu_op;
    assign ex_pc         = stage_q.pc;
    assign ex_imm        = stage_q.imm;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign ex_mem_to_reg = stage_q.mem_to_reg;
    assign ex_branch     = stage_q.branch;
    assign hazard_stall  = load_use_c;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a behavioural model predicts
// each cycle's outputs into a scoreboard queue, popped after the DUT updates.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        stall, flush;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [63:0] ex_mem_result, mem_wb_result;
    logic [63:0] alu_a, alu_b, store_data, ex_pc, ex_imm;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, hazard_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .stall(stall), .flush(flush),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .hazard_stall(hazard_stall)
    );

    typedef struct packed {
        logic [63:0] d1, d2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        src, rw, mr, mw, m2r, br;
    } model_t;

    typedef struct packed {
        logic [63:0] a, b, sd, pc, imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [4:0]  ctrl;
        logic        hz;
    } exp_t;

    model_t m;
    exp_t   sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] d);
        if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == idx) return ex_mem_result;
        if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == idx) return mem_wb_result;
        return d;
    endfunction

    function automatic logic ref_hz(input model_t s);
        return s.mr && s.rd != 5'd0 && (s.rd == id_rs1 || s.rd == id_rs2);
    endfunction

    function automatic exp_t model_out(input model_t s);
        exp_t e;
        e.a    = ref_fwd(s.rs1, s.d1);
        e.sd   = ref_fwd(s.rs2, s.d2);
        e.b    = s.src ? s.imm : e.sd;
        e.pc   = s.pc;
        e.imm  = s.imm;
        e.rd   = s.rd;
        e.op   = s.op;
        e.ctrl = {s.rw, s.mr, s.mw, s.m2r, s.br};
        e.hz   = ref_hz(s);
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".alu_a"}, alu_a, e.a);
        check({tag, ".alu_b"}, alu_b, e.b);
        check({tag, ".store_data"}, store_data, e.sd);
        check({tag, ".alu_op"}, 64'(alu_op), 64'(e.op));
        check({tag, ".ex_pc"}, ex_pc, e.pc);
        check({tag, ".ex_imm"}, ex_imm, e.imm);
        check({tag, ".ex_rd"}, 64'(ex_rd), 64'(e.rd));
        check({tag, ".ctrl"}, 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
              64'(e.ctrl));
        check({tag, ".hazard"}, 64'(hazard_stall), 64'(e.hz));
    endtask

    // Advance one clock: predict next state from current inputs, then compare.
    task automatic cycle(input string tag);
        logic hz;
        hz = ref_hz(m);
        if (reset || flush || hz) begin
            m = '0;
        end else if (!stall) begin
            m = '{d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, pc: id_pc,
                  rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_alu_op,
                  src: id_alu_src, rw: id_reg_write, mr: id_mem_read,
                  mw: id_mem_write, m2r: id_mem_to_reg, br: id_branch};
        end
        sb_q.push_back(model_out(m));
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Combinational re-check without a clock edge.
    task automatic settle(input string tag);
        sb_q.push_back(model_out(m));
        #1;
        compare_out(tag);
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                          input logic [63:0] pc, input logic [3:0] op, input logic src,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic br);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
        id_alu_op = op; id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br;
    endtask

    task automatic set_rand_id();
        set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        m = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_mem_rd = '0; ex_mem_reg_write = 1'b0; ex_mem_result = '0;
        mem_wb_rd = '0; mem_wb_reg_write = 1'b0; mem_wb_result = '0;
        set_rand_id();

        // Reset held two cycles with arbitrary ID inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_rand_id();
            cycle("reset");
        end
        check("reset_alu_op", 64'(alu_op), 64'd0);
        check("reset_hazard", 64'(hazard_stall), 64'd0);

        // EX/MEM has priority over MEM/WB for rs1 = 5.
        @(negedge clk);
        reset = 1'b0;
        set_id(5'd5, 5'd6, 5'd3, 64'h1111, 64'h2222, 64'h30, 64'h1000, 4'hA,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1; ex_mem_result = 64'hAA;
        mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1; mem_wb_result = 64'hBB;
        cycle("fwd_capture");
        check("fwd_exmem_prio", alu_a, 64'hAA);
        check("fwd_alu_b_reg", alu_b, 64'h2222);
        ex_mem_reg_write = 1'b0;
        settle("fwd_drop_exmem");
        check("fwd_memwb", alu_a, 64'hBB);

        // x0 is never forwarded; b operand takes the immediate.
        @(negedge clk);
        set_id(5'd0, 5'd0, 5'd4, 64'd0, 64'd0, 64'h10, 64'h1004, 4'h3,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b1; ex_mem_result = 64'hFF;
        mem_wb_reg_write = 1'b0;
        cycle("x0_imm");
        check("x0_store_data", store_data, 64'd0);
        check("imm_alu_b", alu_b, 64'h10);
        check("x0_alu_a", alu_a, 64'd0);

        // Load-use: load to x7, then a store reading x7.
        @(negedge clk);
        ex_mem_reg_write = 1'b0;
        set_id(5'd1, 5'd2, 5'd7, 64'h5, 64'h6, 64'h8, 64'h1008, 4'h0,
               1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("load_capture");
        @(negedge clk);
        set_id(5'd3, 5'd7, 5'd0, 64'h77, 64'h88, 64'h4, 64'h100C, 4'h0,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle("lu_detect");
        check("lu_hazard_set", 64'(hazard_stall), 64'd1);
        cycle("lu_bubble");
        check("lu_bubble_rw", 64'(ex_reg_write), 64'd0);
        check("lu_bubble_mw", 64'(ex_mem_write), 64'd0);
        check("lu_hazard_clear", 64'(hazard_stall), 64'd0);
        @(negedge clk);
        cycle("lu_replay");
        check("lu_replay_mw", 64'(ex_mem_write), 64'd1);
        check("lu_replay_pc", ex_pc, 64'h100C);

        // Flush beats stall.
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        set_id(5'd2, 5'd3, 5'd9, 64'h9, 64'h9, 64'h9, 64'h2000, 4'h7,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("flush_stall");
        check("flush_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}), 64'd0);
        check("flush_rd", 64'(ex_rd), 64'd0);

        // Capture, then hold through three stalled edges.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        set_id(5'd8, 5'd9, 5'd10, 64'hABC, 64'hDEF, 64'h44, 64'h3000, 4'h5,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            set_id(5'd11, 5'd12, 5'd13, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 64'h4000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle("stall_hold");
            check("stall_pc", ex_pc, 64'h3000);
            check("stall_rd", 64'(ex_rd), 64'd10);
        end

        // Reset during stall clears state.
        @(negedge clk);
        reset = 1'b1;
        cycle("mid_stall_reset");
        check("msr_rd", 64'(ex_rd), 64'd0);
        check("msr_branch", 64'(ex_branch), 64'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;

        // Random traffic with dense register reuse.
        for (int i = 0; i < 60; i++) begin
            set_rand_id();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_reg_write = 1'($urandom);
            ex_mem_result = {$urandom, $urandom};
            mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_reg_write = 1'($urandom);
            mem_wb_result = {$urandom, $urandom};
            cycle("random");
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end for the 64-bit ALU in the pipelined RV64 core.
- Captures decoded operands and control from ID each cycle, and resolves EX/MEM and MEM/WB data hazards with forwarding muxes.
- Detects load-use hazards, inserts a one-cycle bubble, and requests an upstream stall.
- Drives the ALU inputs a, b and 4-bit ALUOp directly, and passes memory/writeback control downstream.

Parameters:
- XLEN, 64, datapath width.
- RADDR, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1_data  in  XLEN  register-file read data for rs1.
- id_rs2_data  in  XLEN  register-file read data for rs2.
- id_imm  in  XLEN  sign-extended immediate.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  RADDR each  register indices.
- id_alu_op  in  4  ALU operation code.
- id_alu_src  in  1  selects b operand: 1 = immediate, 0 = rs2.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control.
- stall  in  1  hold register contents.
- flush  in  1  load a bubble (branch taken).
- ex_mem_rd  in  RADDR  EX/MEM destination register.
- ex_mem_reg_write  in  1  EX/MEM write enable.
- ex_mem_result  in  XLEN  EX/MEM ALU result.
- mem_wb_rd  in  RADDR  MEM/WB destination register.
- mem_wb_reg_write  in  1  MEM/WB write enable.
- mem_wb_result  in  XLEN  MEM/WB writeback data.
- alu_a  out  XLEN  ALU operand a.
- alu_b  out  XLEN  ALU operand b.
- alu_op  out  4  ALUOp to the ALU.
- store_data  out  XLEN  forwarded rs2 for stores.
- ex_pc, ex_imm  out  XLEN each  registered pc and immediate.
- ex_rd  out  RADDR  registered destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control.
- hazard_stall  out  1  request to freeze PC and IF/ID.

Behaviour:
- Register update on rising clk, priority reset > flush > load-use bubble > stall > capture.
- reset: all registered fields cleared to 0.
  - Resulting outputs: alu_op = 4'b0000, all control = 0, ex_rd = 0.
  - alu_a = alu_b = store_data = 0 unless forwarding matches x0, which is excluded.
  - hazard_stall = 0.
- flush: control fields and rd cleared (bubble); data fields cleared to 0. flush overrides stall and hazard.
- Load-use hazard (combinational): hazard_stall = ex_mem_read_q & (ex_rd_q != 0) & (ex_rd_q == id_rs1 | ex_rd_q == id_rs2).
  - When hazard_stall is 1 and flush is 0, the next edge loads a bubble and the ID inputs are not consumed.
  - Upstream holds ID, so the instruction re-presents the next cycle.
- stall with no hazard: all registers hold.
- Otherwise all id_* fields are captured. Latency is ID to EX outputs in 1 cycle.
- Forward A (combinational on registered rs1_q):
  - If ex_mem_reg_write & ex_mem_rd != 0 & ex_mem_rd == rs1_q, use ex_mem_result.
  - Else if mem_wb_reg_write & mem_wb_rd != 0 & mem_wb_rd == rs1_q, use mem_wb_result.
  - Else use rs1_data_q.
  - EX/MEM has priority over MEM/WB when both match.
- Forward B: same rules on rs2_q produce fwd_b.
- Outputs from the forwarded values:
  - alu_a = fwd_a.
  - alu_b = alu_src_q ? imm_q : fwd_b.
  - store_data = fwd_b, always the forwarded rs2 even when alu_src_q = 1.
- Register x0 is never forwarded; reads of x0 use the registered data (0 from the register file).
- Forwarding is purely combinational, so the ALU sees the updated operands in the same cycle the EX/MEM or MEM/WB values change.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset: reset=1 for 2 cycles with arbitrary ID inputs -> all ex_* = 0, alu_op = 0, hazard_stall = 0; on release, next edge captures ID.
- EX/MEM forward: rs1_q = 5; ex_mem_rd = 5, ex_mem_reg_write = 1, ex_mem_result = 0xAA; mem_wb_rd = 5, mem_wb_result = 0xBB -> alu_a = 0xAA (priority). Drop ex_mem_reg_write -> alu_a = 0xBB.
- x0 and immediate select: rs2_q = 0, ex_mem_rd = 0 with write enabled, result 0xFF -> store_data = register data 0. With alu_src_q = 1 and imm = 0x10 -> alu_b = 0x10.
- Load-use: load with ex_rd_q = 7 in EX; id_rs2 = 7 -> hazard_stall = 1. Next edge: ex_reg_write = 0, ex_mem_write = 0 (bubble). Following edge captures the held instruction and hazard_stall = 0.
- Flush vs stall: stall = 1 and flush = 1 together -> bubble loaded, all control = 0. stall alone for 3 cycles -> outputs unchanged across the 3 edges.
- Mid-stall reset: stall = 1 with a valid instruction held; reset = 1 -> next edge clears all state regardless of stall.
